phase_address_sequencer: RTL and testbench

Parametrised generator for the micro-step address of the paper processor. It replaces the external 2-bit counter plus the fixed status decode with one block. The block owns the phase counter, steps it under an advance handshake, and pulses done on wrap. A status event forces the trap address, all ones. The address feeds the control-store / operand-select mux exactly as the old 2-bit address did.

---
 rtl/addr_seq_pkg.sv | 21 ++
 rtl/phase_counter.sv | 43 ++++
 rtl/phase_address_sequencer.sv | 123 ++++++++++++
 tb/tb_phase_address_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/addr_seq_pkg.sv
// rtl/addr_seq_pkg.sv - shared encodings and defaults for the phase address sequencer
//
// Purpose: state encodings, default sizing and the trap address helper used by
// phase_address_sequencer and phase_counter.
package addr_seq_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int PHASES_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } seq_state_t;

  // All ones of the given width; the trap address sits above every phase address.
  function automatic int unsigned trap_addr(input int width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - modulo-PHASES phase counter with clear, hold and increment
//
// Purpose: owns the micro-step phase count; wraps from PHASES-1 back to 0.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clr          force count to 0 (beats hold and inc)
//   inc          step count by one, modulo PHASES
//   hold         freeze count (beats inc)
//   count        current phase count
//   last         count == PHASES-1
module phase_counter
  import addr_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PHASES = PHASES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  input  logic              hold,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(PHASES - 1);

  assign last = (count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (count > LAST_CNT) begin
      // Out-of-range value can only come from an upset; fall back to phase 0.
      count <= '0;
    end else if (hold) begin
      count <= count;
    end else if (inc) begin
      count <= last ? '0 : count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/phase_address_sequencer.sv
// rtl/phase_address_sequencer.sv - micro-step address sequencer with status trap
//
// Purpose: steps through addresses 0..PHASES-1 under an advance handshake,
// pulses done on the final step and forces TRAP_ADDR while trapped.
// Optional feature macro: ADDR_SEQ_STICKY_EN (TRAP latches until clear).
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        begin a sequence (IDLE only)
//   advance      step to next phase (RUN only)
//   status       exception/status request
//   clear        release from a sticky TRAP (sticky build only)
//   address      current micro-step address
//   counter      current phase count, frozen in TRAP
//   busy         high in RUN or TRAP
//   done         one-cycle pulse after the final phase step
//   trap         high while in TRAP
module phase_address_sequencer
  import addr_seq_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter int          PHASES    = PHASES_DEF,
  parameter int unsigned TRAP_ADDR = trap_addr(ADDR_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              advance,
  input  logic              status,
  input  logic              clear,
  output logic [ADDR_W-1:0] address,
  output logic [ADDR_W-1:0] counter,
  output logic              busy,
  output logic              done,
  output logic              trap
);

  localparam logic [ADDR_W-1:0] TRAP_A = TRAP_ADDR[ADDR_W-1:0];

  seq_state_t state_q, state_d;
  logic       done_q, done_d;
  logic       cnt_clr, cnt_inc, cnt_hold, cnt_last;

  phase_counter #(
    .ADDR_W (ADDR_W),
    .PHASES (PHASES)
  ) u_phase_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .hold  (cnt_hold),
    .count (counter),
    .last  (cnt_last)
  );

`ifdef ADDR_SEQ_STICKY_EN
  // Sticky: only clear (without a concurrent status) leaves TRAP.
  logic trap_exit;
  assign trap_exit = clear && !status;
`else
  logic trap_exit;
  logic unused_clear;
  assign trap_exit    = !status;
  assign unused_clear = clear;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    cnt_hold = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The done cycle is already IDLE; start is only taken one cycle later.
        if (start && !done_q) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (status) begin
          state_d  = ST_TRAP;
          cnt_hold = 1'b1;
        end else if (advance) begin
          if (cnt_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_TRAP: begin
        cnt_hold = 1'b1;
        if (trap_exit) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  assign busy    = (state_q == ST_RUN) || (state_q == ST_TRAP);
  assign trap    = (state_q == ST_TRAP);
  assign done    = done_q;
  assign address = trap ? TRAP_A : counter;

endmodule

// File: tb/tb_phase_address_sequencer.sv
// tb/tb_phase_address_sequencer.sv - directed self-checking bench for phase_address_sequencer
module tb_phase_address_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       advance = 1'b0;
  logic       status = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] address;
  logic [1:0] counter;
  logic       busy;
  logic       done;
  logic       trap;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  phase_address_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .advance (advance),
    .status  (status),
    .clear   (clear),
    .address (address),
    .counter (counter),
    .busy    (busy),
    .done    (done),
    .trap    (trap)
  );

  // Inputs are changed 1 time unit after a rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if (address !== 2'd0) begin n_fail++; $display("FAIL reset_address: got %0d expected 0", address); end
    n_cmp++; if (counter !== 2'd0) begin n_fail++; $display("FAIL reset_counter: got %0d expected 0", counter); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap: got %b expected 0", trap); end
  endtask

  task automatic test_sequence();
    logic [1:0] exp_addr [3] = '{2'd0, 2'd1, 2'd2};
    start = 1'b1;
    tick();
    start = 1'b0;
    advance = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (address !== exp_addr[i]) begin n_fail++; $display("FAIL seq_address[%0d]: got %0d expected %0d", i, address, exp_addr[i]); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL seq_busy[%0d]: got %b expected 1", i, busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL seq_done_early[%0d]: got %b expected 0", i, done); end
      tick();
    end
    advance = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL seq_done: got %b expected 1", done); end
    n_cmp++; if (address !== 2'd0) begin n_fail++; $display("FAIL seq_end_address: got %0d expected 0", address); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL seq_end_busy: got %b expected 0", busy); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL seq_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_trap_hold();
    start = 1'b1; tick(); start = 1'b0;
    advance = 1'b1; tick(); advance = 1'b0;
    status = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (address !== 2'd3) begin n_fail++; $display("FAIL trap_address[%0d]: got %0d expected 3", i, address); end
      n_cmp++; if (trap !== 1'b1) begin n_fail++; $display("FAIL trap_flag[%0d]: got %b expected 1", i, trap); end
      n_cmp++; if (counter !== 2'd1) begin n_fail++; $display("FAIL trap_counter[%0d]: got %0d expected 1", i, counter); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL trap_busy[%0d]: got %b expected 1", i, busy); end
    end
    status = 1'b0;
    tick();
    n_cmp++; if (address !== 2'd1) begin n_fail++; $display("FAIL trap_resume_address: got %0d expected 1", address); end
    n_cmp++; if (trap !== 1'b0) begin n_fail++; $display("FAIL trap_resume_flag: got %b expected 0", trap); end
    advance = 1'b1; tick(); tick(); advance = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL trap_finish_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_priority();
    start = 1'b1; tick(); start = 1'b0;
    advance = 1'b1; tick();
    status = 1'b1;
    tick();
    n_cmp++; if (address !== 2'd3) begin n_fail++; $display("FAIL prio_address: got %0d expected 3", address); end
    n_cmp++; if (counter !== 2'd1) begin n_fail++; $display("FAIL prio_counter: got %0d expected 1", counter); end
    status = 1'b0; advance = 1'b0;
    tick();
    n_cmp++; if (address !== 2'd1) begin n_fail++; $display("FAIL prio_release: got %0d expected 1", address); end
    advance = 1'b1;
    tick();
    n_cmp++; if (address !== 2'd2) begin n_fail++; $display("FAIL prio_step: got %0d expected 2", address); end
    tick();
    advance = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL prio_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_sticky();
    start = 1'b1; tick(); start = 1'b0;
    advance = 1'b1; tick(); tick(); advance = 1'b0;
    status = 1'b1;
    tick();
    status = 1'b0;
    n_cmp++; if (address !== 2'd3) begin n_fail++; $display("FAIL pulse_trap_address: got %0d expected 3", address); end
`ifdef ADDR_SEQ_STICKY_EN
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (address !== 2'd3) begin n_fail++; $display("FAIL sticky_hold[%0d]: got %0d expected 3", i, address); end
    end
    clear = 1'b1; status = 1'b1;
    tick();
    n_cmp++; if (trap !== 1'b1) begin n_fail++; $display("FAIL sticky_clear_status: got %b expected 1", trap); end
    status = 1'b0;
    tick();
    clear = 1'b0;
    n_cmp++; if (address !== 2'd2) begin n_fail++; $display("FAIL sticky_release: got %0d expected 2", address); end
`else
    clear = 1'b1;
    tick();
    n_cmp++; if (address !== 2'd2) begin n_fail++; $display("FAIL nonsticky_resume: got %0d expected 2", address); end
    status = 1'b1;
    tick();
    tick();
    n_cmp++; if (address !== 2'd3) begin n_fail++; $display("FAIL nonsticky_clear_ignored: got %0d expected 3", address); end
    status = 1'b0; clear = 1'b0;
    tick();
    n_cmp++; if (address !== 2'd2) begin n_fail++; $display("FAIL nonsticky_release: got %0d expected 2", address); end
`endif
    n_cmp++; if (trap !== 1'b0) begin n_fail++; $display("FAIL sticky_trap_clear: got %b expected 0", trap); end
    advance = 1'b1; tick(); advance = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL sticky_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_reset_in_trap();
    start = 1'b1; tick(); start = 1'b0;
    advance = 1'b1; tick(); advance = 1'b0;
    status = 1'b1;
    tick();
    n_cmp++; if (trap !== 1'b1) begin n_fail++; $display("FAIL rst_trap_entry: got %b expected 1", trap); end
    reset = 1'b1;
    tick();
    reset = 1'b0; status = 1'b0;
    n_cmp++; if (address !== 2'd0) begin n_fail++; $display("FAIL rst_trap_address: got %0d expected 0", address); end
    n_cmp++; if (counter !== 2'd0) begin n_fail++; $display("FAIL rst_trap_counter: got %0d expected 0", counter); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_trap_busy: got %b expected 0", busy); end
    n_cmp++; if (trap !== 1'b0) begin n_fail++; $display("FAIL rst_trap_trap: got %b expected 0", trap); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_trap_done: got %b expected 0", done); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_trap_stays_idle: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; tick(); start = 1'b0;
    advance = 1'b1; tick(); advance = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      n_cmp++; if (address !== 2'd1) begin n_fail++; $display("FAIL hold_address[%0d]: got %0d expected 1", i, address); end
    end
    start = 1'b0;
    advance = 1'b1; tick(); tick(); advance = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b expected 1", done); end
    start = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done: got %b expected 0", busy); end
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b expected 1", busy); end
    n_cmp++; if (address !== 2'd0) begin n_fail++; $display("FAIL b2b_restart_address: got %0d expected 0", address); end
    advance = 1'b1; tick(); tick(); tick(); advance = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b expected 1", done); end
    tick();
    // start and status together in IDLE: RUN first, status re-sampled in RUN.
    start = 1'b1; status = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (trap !== 1'b0) begin n_fail++; $display("FAIL idle_status_trap: got %b expected 0", trap); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL idle_status_busy: got %b expected 1", busy); end
    tick();
    status = 1'b0;
    n_cmp++; if (address !== 2'd3) begin n_fail++; $display("FAIL idle_status_resample: got %0d expected 3", address); end
    tick();
    n_cmp++; if (address !== 2'd0) begin n_fail++; $display("FAIL idle_status_resume: got %0d expected 0", address); end
  endtask

  initial begin
    #2;
    test_reset();
    test_sequence();
    test_trap_hold();
    test_priority();
    test_sticky();
    test_reset_in_trap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
